adder_flit_scheduler: RTL and testbench
=======================================

# adder_flit_scheduler

Sequencer and round-robin arbiter that shares one N-bit adder between NREQ flit-stream requesters for energy characterization runs. It grants the adder for a whole packet, registers each sum, and enforces a programmable idle gap between packets to set link utilization. It sits between the flit sources and the adder datapath, replacing per-source direct drive of the adder operands.

## Interface
- N, 30, operand and sum width
- NREQ, 4, number of requesters (≥2)
- MAXLEN, 20, max flits per grant; the grant is released after MAXLEN flits even without last
- GAP, 7, idle cycles inserted after every packet (0 allowed)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  NREQ  requester k has a flit
- in_last  in  NREQ  flit is last of packet
- in_a  in  NREQ*N  operand A, requester k at [k*N +: N]
- in_b  in  NREQ*N  operand B, same packing
- in_ready  out  NREQ  one-hot or zero; flit k accepted when in_valid[k] & in_ready[k] at a rising edge
- out_valid  out  1  registered sum valid
- out_sum  out  N  (a+b)[N-1:0]
- out_carry  out  1  (a+b)[N]
- out_id  out  $clog2(NREQ)  requester of the sum
- out_last  out  1  sum is the packet's final flit
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, BURST, GAP. Reset → IDLE, rr_ptr = NREQ-1, flit count 0. All outputs are 0 in reset.
- IDLE: if any in_valid, grant the first valid index after rr_ptr (cyclic), go to BURST. Otherwise stay. in_ready is 0.
- BURST: in_ready[g]=1 only. Each accept increments the count. An accept with in_last[g]=1, or with count==MAXLEN-1, ends the packet:
  - out_last is asserted with that sum.
  - rr_ptr←g, count←0.
  - Next state is GAP if GAP>0, else IDLE.
- BURST with in_valid[g]=0: hold the grant indefinitely. No other requester is served and no timeout applies.
- Changes to in_valid of non-granted requesters during BURST or GAP are ignored.
- GAP: in_ready=0. Count GAP cycles, then go to IDLE.
- Arithmetic: (N+1)-bit sum of the unsigned operands. Wrap-around is exposed via out_carry. No saturation.
- Simultaneous requests in IDLE: round-robin order only. No fixed priority except after reset, when requester 0 wins.

## Timing
- Grant decision: 1 cycle. Requests seen at edge e0 → in_ready high after e0 → earliest accept at e1.
- Sum latency: 1 cycle. A flit accepted at edge e gives out_valid, out_sum, out_carry, out_id and out_last valid from e until the next edge.
- Back-to-back accepts give back-to-back out_valid (1 flit/cycle).
- Packet-to-packet spacing: last accept → GAP cycles in GAP → 1 cycle IDLE → next accept. Minimum dead time is GAP+1 cycles.
- rst asserted mid-packet: the FSM is forced to IDLE and all outputs go to 0 immediately. An in-flight sum is discarded.

## Configuration
- ADDER_OP_HOLD_EN defined: when out_valid=0, out_sum, out_carry and out_id hold their last values, minimizing output toggling.
- ADDER_OP_HOLD_EN not defined: out_sum, out_carry, out_id and out_last are forced to 0 in every cycle without an accept.
- out_valid behaviour is identical in both builds.

## Test plan
- Requester 0 only, 20-flit packet, flit 1 a=3FFFFFFF b=00000001:
  - first sum is out_sum=0, out_carry=1, out_id=0.
  - out_last is set on the 20th sum.
  - in_ready is then 0 for 8 cycles (7 GAP + 1 IDLE).
- Requesters 0 and 2 continuously valid with 3-flit packets:
  - grant order is 0,2,0,2.
  - each packet gives 3 consecutive out_valid cycles.
  - GAP is honoured between packets.
- Requester 1 offers 25 flits with no in_last:
  - forced release after 20 flits, out_last on the 20th.
  - the remaining 5 flits are served on the next grant to requester 1.
- Granted requester drops in_valid for 3 cycles mid-packet while requester 3 is valid:
  - no out_valid during those 3 cycles.
  - grant is kept and requester 3 is not served until the packet ends.
- rst pulsed during flit 10 of a packet:
  - all outputs are 0 during reset.
  - after release, with requesters 0 and 3 valid, the first grant goes to requester 0.
- Both builds, 2-flit packet followed by gap cycles:
  - with ADDER_OP_HOLD_EN, out_sum holds the last sum through the gap.
  - without it, out_sum=0 during the gap.

Source files
------------

// File: rtl/adder_flit_scheduler.sv
// adder_flit_scheduler: round-robin sharing of one N-bit adder among NREQ flit requesters, granted per packet.
// Latency: 1 cycle grant decision, 1 cycle registered sum; GAP+1 dead cycles between packets.
// Backpressure: in_ready only to the granted requester in BURST; grant held while that requester stalls.
// Build option ADDER_OP_HOLD_EN: out_sum/out_carry/out_id hold their last values while out_valid is low.
module adder_flit_scheduler #(
    parameter int N      = 30,
    parameter int NREQ   = 4,
    parameter int MAXLEN = 20,
    parameter int GAP    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           in_valid,
    input  logic [NREQ-1:0]           in_last,
    input  logic [NREQ*N-1:0]         in_a,
    input  logic [NREQ*N-1:0]         in_b,
    output logic [NREQ-1:0]           in_ready,
    output logic                      out_valid,
    output logic [N-1:0]              out_sum,
    output logic                      out_carry,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic                      out_last,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXLEN + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gcnt;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic            acc;
    logic            pkt_end;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;

    // Round-robin pick: first valid requester after rr_ptr, wrapping around.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_vld && in_valid[(int'(rr_ptr) + i) % NREQ]) begin
                pick     = IW'((int'(rr_ptr) + i) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    // Accept qualification and operand mux from the granted requester.
    always_comb begin
        acc     = (state == S_BURST) && in_valid[grant];
        pkt_end = acc && (in_last[grant] || (cnt == CW'(MAXLEN - 1)));
        op_a    = in_a[int'(grant)*N +: N];
        op_b    = in_b[int'(grant)*N +: N];
    end

    // Next-state and handshake outputs; gap length of zero skips straight back to IDLE.
    always_comb begin
        state_nx = state;
        in_ready = '0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (pick_vld) state_nx = S_BURST;
            end
            S_BURST: begin
                in_ready[grant] = 1'b1;
                if (pkt_end) state_nx = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gcnt == GW'(GAP - 1)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Control state: FSM, latched grant, round-robin pointer, flit and gap counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= IW'(NREQ - 1);
            cnt    <= '0;
            gcnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && pick_vld) grant <= pick;
            if (pkt_end) begin
                rr_ptr <= grant;
                cnt    <= '0;
            end else if (acc) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_GAP) gcnt <= gcnt + 1'b1;
            else                gcnt <= '0;
        end
    end

    // Registered sum; idle cycles either zero the result fields or hold them to cut toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= acc;
            if (acc) begin
                {out_carry, out_sum} <= {1'b0, op_a} + {1'b0, op_b};
                out_id               <= grant;
                out_last             <= pkt_end;
            end else begin
`ifdef ADDER_OP_HOLD_EN
                out_last  <= 1'b0;
`else
                out_sum   <= '0;
                out_carry <= 1'b0;
                out_id    <= '0;
                out_last  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_flit_scheduler.sv
// Bench for adder_flit_scheduler: directed scenarios plus randomized traffic against a transaction-level model.
// The model tracks owner / dead-cycle budget / round-robin pointer and predicts every output each cycle.
// Inputs are driven on the falling edge; outputs are compared on the falling edge before redriving.
module tb_adder_flit_scheduler;
    localparam int N = 30, NREQ = 4, MAXLEN = 20, GAP = 7;
    localparam int IW = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0]   in_valid, in_last, in_ready;
    logic [NREQ*N-1:0] in_a, in_b;
    logic              out_valid, out_carry, out_last, busy;
    logic [N-1:0]      out_sum;
    logic [IW-1:0]     out_id;

    always #5 clk = ~clk;

    adder_flit_scheduler #(.N(N), .NREQ(NREQ), .MAXLEN(MAXLEN), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .out_valid(out_valid), .out_sum(out_sum), .out_carry(out_carry),
        .out_id(out_id), .out_last(out_last), .busy(busy)
    );

    int n_cmp = 0, n_bad = 0;

    // Flit sources: remaining flits, packet length (0 = never last), position in packet, stall.
    int          rem  [NREQ];
    int          plen [NREQ];
    int          idx  [NREQ];
    bit          stall[NREQ];
    bit          rnd_stall = 0;
    logic [N-1:0] da[NREQ], db[NREQ];

    // Reference model: who holds the adder, how many edges remain before arbitration, rr pointer.
    int owner, dead, ptr, cnt;
    logic          e_vld, e_carry, e_last;
    logic [N-1:0]  e_sum;
    logic [IW-1:0] e_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] er;
        er = '0;
        if (owner >= 0) er[owner] = 1'b1;
        chk("in_ready",  in_ready,  er);
        chk("busy",      busy,      (owner >= 0) || (dead > 0));
        chk("out_valid", out_valid, e_vld);
        chk("out_sum",   out_sum,   e_sum);
        chk("out_carry", out_carry, e_carry);
        chk("out_id",    out_id,    e_id);
        chk("out_last",  out_last,  e_last);
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (rnd_stall) stall[k] = ($urandom_range(0, 3) == 0);
            in_valid[k]        = (rem[k] > 0) && !stall[k];
            in_last[k]         = (plen[k] != 0) && (idx[k] == plen[k] - 1);
            in_a[k*N +: N]     = da[k];
            in_b[k*N +: N]     = db[k];
        end
    endtask

    // Effect of one rising edge given the inputs currently driven.
    task automatic model_edge();
        logic [N:0] s;
        bit fin;
        if (owner >= 0 && in_valid[owner]) begin
            s       = {1'b0, da[owner]} + {1'b0, db[owner]};
            cnt     = cnt + 1;
            fin     = in_last[owner] || (cnt == MAXLEN);
            e_vld   = 1'b1;
            e_sum   = s[N-1:0];
            e_carry = s[N];
            e_id    = IW'(owner);
            e_last  = fin;
            rem[owner]--;
            idx[owner]++;
            da[owner] = N'($urandom);
            db[owner] = N'($urandom);
            if (fin) begin
                idx[owner] = 0;
                ptr   = owner;
                owner = -1;
                cnt   = 0;
                dead  = GAP;
            end
        end else begin
            e_vld  = 1'b0;
            e_last = 1'b0;
`ifndef ADDER_OP_HOLD_EN
            e_sum   = '0;
            e_carry = 1'b0;
            e_id    = '0;
`endif
            if (owner < 0) begin
                if (dead > 0) dead--;
                else begin
                    for (int i = 1; i <= NREQ; i++)
                        if (owner < 0 && in_valid[(ptr + i) % NREQ]) owner = (ptr + i) % NREQ;
                end
            end
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic step();
        check_all();
        drive();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic bit model_idle();
        bit r;
        r = (owner < 0) && (dead == 0) && !e_vld;
        for (int k = 0; k < NREQ; k++) if (rem[k] != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!model_idle() && t < budget) begin step(); t++; end
        if (t >= budget) begin
            n_cmp++; n_bad++;
            $error("FAIL timeout waiting for idle, budget=%0d", budget);
        end
        step();
    endtask

    // Called on a falling edge; asserts rst mid-cycle, checks outputs cleared, releases on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NREQ; k++) begin rem[k] = 0; idx[k] = 0; stall[k] = 0; end
        owner = -1; dead = 0; ptr = NREQ - 1; cnt = 0;
        e_vld = 0; e_sum = '0; e_carry = 0; e_id = '0; e_last = 0;
        check_all();
        drive();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0; in_last = '0; in_a = '0; in_b = '0;
        for (int k = 0; k < NREQ; k++) begin da[k] = N'($urandom); db[k] = N'($urandom); end
        @(negedge clk);
        do_reset();

        // Requester 0 alone, 20-flit packet; first flit wraps to sum 0 with carry.
        da[0] = 30'h3FFF_FFFF; db[0] = 30'h0000_0001;
        plen[0] = 20; rem[0] = 20;
        wait_done(200);

        // Requesters 0 and 2, two 3-flit packets each: alternation with gaps.
        plen[0] = 3; rem[0] = 6;
        plen[2] = 3; rem[2] = 6;
        wait_done(300);

        // Granted requester 0 stalls 3 cycles mid-packet while requester 3 waits.
        plen[0] = 6; rem[0] = 6;
        step(); step();
        plen[3] = 2; rem[3] = 2;
        for (int t = 0; t < 100 && idx[0] < 3; t++) step();
        stall[0] = 1;
        step(); step(); step();
        stall[0] = 0;
        wait_done(300);

        // Requester 1 offers 25 flits without last: forced release at 20, remainder on next grant.
        plen[1] = 0; rem[1] = 25;
        for (int t = 0; t < 300 && rem[1] > 0; t++) step();
        step(); step();

        // Requester 1 still holds the grant; reset during its 10th flit of a new packet.
        plen[1] = 15; rem[1] = 15; idx[1] = 0;
        for (int t = 0; t < 100 && idx[1] < 9; t++) step();
        do_reset();
        plen[0] = 2; rem[0] = 2;
        plen[3] = 2; rem[3] = 2;
        wait_done(300);

        // Randomized traffic with random stalls.
        rnd_stall = 1;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                plen[k] = $urandom_range(1, 12);
                rem[k]  = plen[k] * $urandom_range(0, 2);
                idx[k]  = 0;
            end
            wait_done(3000);
        end
        rnd_stall = 0;
        for (int k = 0; k < NREQ; k++) stall[k] = 0;

        // Short 2-flit packet followed by idle cycles: result fields held or zeroed.
        plen[2] = 2; rem[2] = 2;
        wait_done(100);
        for (int t = 0; t < 4; t++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
